rf_scoreboard: RTL
==================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 Parameter DATA_W, 16, register and data width.
REQ-002 Parameter NREG, 8, register count; addresses are 3 bits; R7 is the PC register.
REQ-003 Parameter MAX_INFL, 3, maximum in-flight pending writes per register.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 RF_A1_In, RF_A2_In  input  3 each  read addresses for the instruction in RR.
REQ-007 Use_A1_In, Use_A2_In  input  1 each  instruction in RR actually reads A1 / A2.
REQ-008 RF_D1_Out, RF_D2_Out  output  16 each  read data, combinational, with WB bypass.
REQ-009 Issue_Valid_In  input  1  instruction in RR requests to advance to EX this cycle.
REQ-010 Issue_A3_In  input  3  destination of the issuing instruction.
REQ-011 Issue_Wr_En_In  input  1  issuing instruction will write Issue_A3_In.
REQ-012 RF_A3_From_WB_In, RF_D3_From_WB_In, RR_Write_En_In  input  3/16/1  writeback port.
REQ-013 PC_In, PC_Wr_En_In  input  16/1  PC update into R7.
REQ-014 Flush_In  input  1  pipeline flush; discards pending-write tracking.
REQ-015 Stall_Out  output  1  RR must hold; the issue is not accepted.
REQ-016 Issue_Accept_Out  output  1  Issue_Valid_In and not Stall_Out.

Function
REQ-017 Storage: NREG x DATA_W registers; one writeback port plus the R7 PC port, both applied on posedge.
REQ-018 WB write: when RR_Write_En_In=1, reg[RF_A3_From_WB_In] <= RF_D3_From_WB_In.
REQ-019 PC write: when PC_Wr_En_In=1, R7 <= PC_In, unless WB writes R7 in the same cycle; the WB write wins.
REQ-020 Read bypass: if RR_Write_En_In=1 and RF_A3_From_WB_In equals RF_A1_In, RF_D1_Out = RF_D3_From_WB_In; otherwise it is the stored value. RF_D2_Out follows the same rule.
REQ-021 Read of R7 with no WB bypass returns the stored R7; the same-cycle PC_In is not bypassed.
REQ-022 Scoreboard: one 2-bit pending count per register, each 0..MAX_INFL.
REQ-023 On an accepted issue with Issue_Wr_En_In=1, count[Issue_A3_In] increments.
REQ-024 On RR_Write_En_In=1, count[RF_A3_From_WB_In] decrements, saturating at 0.
REQ-025 An increment and a decrement of the same register in one cycle leave its count unchanged.
REQ-026 RAW stall, per operand i=1,2: stall when Use_Ai=1 and count[Ai]!=0, except when the WB port retires Ai this cycle with count[Ai]=1 (the bypass supplies the data).
REQ-027 WAW-capacity stall: Issue_Wr_En_In=1 and count[Issue_A3_In]=MAX_INFL, with no retire to that register this cycle.
REQ-028 Stall_Out = Issue_Valid_In AND (any RAW stall OR WAW-capacity stall); it is 0 when Issue_Valid_In=0.
REQ-029 A stalled issue changes no count.
REQ-030 Flush_In=1: all counts <= 0 on the next edge, overriding same-cycle increments. Register writes in that cycle still occur. Stall_Out is still computed from the pre-flush counts.
REQ-031 Latency: a write is visible on RF_Dx_Out in the same cycle via bypass, and from storage from the next cycle.

Reset
REQ-032 rst=1 immediately forces all registers and all counts to 0, independent of clk.
REQ-033 During reset, RF_D1_Out and RF_D2_Out read 0 except for a WB bypass. Stall_Out follows REQ-028 on zero counts, so it is 0 with Issue_Valid_In=0.
REQ-034 Reset asserted mid-operation discards pending counts and register contents; the first edge after deassertion behaves as from the fresh state.

Verification
REQ-035 Reset, then A1=3, Use_A1=1, Issue_Valid=1 -> RF_D1_Out=0, Stall_Out=0, Issue_Accept_Out=1.
REQ-036 Issue writing R2; next cycle, issue reading R2 -> Stall_Out=1. Cycle WB writes R2=16'h00A5 -> Stall_Out=0 and RF_D1_Out=16'h00A5 in that cycle.
REQ-037 Three accepted issues writing R4 with no WB, then a fourth -> Stall_Out=1. With a WB to R4 in the same cycle -> accepted, count stays 3.
REQ-038 PC_Wr_En=1 with PC_In=16'h0040, and WB to R7 =16'h1234 in the same cycle -> R7 reads 16'h1234 next cycle.
REQ-039 Pending count on R5, then Flush_In=1 -> next cycle a read of R5 does not stall. A later WB to R5 leaves its count at 0.
REQ-040 Assert rst asynchronously between edges with count[R1]=2 -> counts and registers are 0 immediately; a read of R1 after release does not stall.

Source files
------------

// File: rtl/rf_scoreboard.sv
// Register file with WB read bypass, an R7 PC port and per-register pending-write
// counters that raise RAW and WAW-capacity stalls for the instruction in RR.
module rf_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int MAX_INFL = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREG)-1:0]    RF_A1_In,
  input  logic [$clog2(NREG)-1:0]    RF_A2_In,
  input  logic                       Use_A1_In,
  input  logic                       Use_A2_In,
  output logic [DATA_W-1:0]          RF_D1_Out,
  output logic [DATA_W-1:0]          RF_D2_Out,
  input  logic                       Issue_Valid_In,
  input  logic [$clog2(NREG)-1:0]    Issue_A3_In,
  input  logic                       Issue_Wr_En_In,
  input  logic [$clog2(NREG)-1:0]    RF_A3_From_WB_In,
  input  logic [DATA_W-1:0]          RF_D3_From_WB_In,
  input  logic                       RR_Write_En_In,
  input  logic [DATA_W-1:0]          PC_In,
  input  logic                       PC_Wr_En_In,
  input  logic                       Flush_In,
  output logic                       Stall_Out,
  output logic                       Issue_Accept_Out
);
  localparam int AW = $clog2(NREG);
  localparam int CW = 2;
  localparam logic [AW-1:0] PC_REG  = AW'(NREG - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFL);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CW-1:0]     cnt_q  [NREG];
  logic [CW-1:0]     cnt_d  [NREG];

  logic wb_hit_a1, wb_hit_a2, wb_hit_a3;
  logic raw1, raw2, waw;

  assign wb_hit_a1 = RR_Write_En_In && (RF_A3_From_WB_In == RF_A1_In);
  assign wb_hit_a2 = RR_Write_En_In && (RF_A3_From_WB_In == RF_A2_In);
  assign wb_hit_a3 = RR_Write_En_In && (RF_A3_From_WB_In == Issue_A3_In);

  // The same-cycle PC_In is deliberately not bypassed; only the WB port is.
  assign RF_D1_Out = wb_hit_a1 ? RF_D3_From_WB_In : regs_q[RF_A1_In];
  assign RF_D2_Out = wb_hit_a2 ? RF_D3_From_WB_In : regs_q[RF_A2_In];

  // A single outstanding write retiring this cycle is covered by the bypass.
  assign raw1 = Use_A1_In && (cnt_q[RF_A1_In] != '0) &&
                !(wb_hit_a1 && (cnt_q[RF_A1_In] == CW'(1)));
  assign raw2 = Use_A2_In && (cnt_q[RF_A2_In] != '0) &&
                !(wb_hit_a2 && (cnt_q[RF_A2_In] == CW'(1)));
  assign waw  = Issue_Wr_En_In && (cnt_q[Issue_A3_In] == CNT_MAX) && !wb_hit_a3;

  assign Stall_Out        = Issue_Valid_In && (raw1 || raw2 || waw);
  assign Issue_Accept_Out = Issue_Valid_In && !Stall_Out;

  always_comb begin
    regs_d = regs_q;
    if (PC_Wr_En_In) regs_d[PC_REG] = PC_In;
    // WB is applied last so it wins over a same-cycle PC write to R7.
    if (RR_Write_En_In) regs_d[RF_A3_From_WB_In] = RF_D3_From_WB_In;
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      if (Flush_In) begin
        cnt_d[r] = '0;
      end else if (Issue_Accept_Out && Issue_Wr_En_In && (Issue_A3_In == AW'(r))) begin
        if (!(RR_Write_En_In && (RF_A3_From_WB_In == AW'(r))))
          cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (RR_Write_En_In && (RF_A3_From_WB_In == AW'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule
